// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, big-endian words into instruction memory.
// Define PROG_LOADER_CKSUM_EN to add a trailing XOR checksum word (CHECK state).
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_halt,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef PROG_LOADER_CKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

`ifdef PROG_LOADER_CKSUM_EN
    localparam state_t TAIL = S_CHECK;
`else
    localparam state_t TAIL = S_DONE;
`endif
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t            r_state, w_next;
    logic [15:0]       r_len;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_shift;
    logic [ADDR_W-1:0] r_word_idx;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
`ifdef PROG_LOADER_CKSUM_EN
    logic [31:0]       r_xor;
`endif

    logic        w_ready, w_accept, w_word_done, w_last_word, w_restart;
    logic [15:0] w_len_n;
    logic [31:0] w_word;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA: w_ready = 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
            S_CHECK:                    w_ready = 1'b1;
`endif
            default:                    w_ready = 1'b0;
        endcase
    end

    assign w_accept    = in_valid & w_ready;
    assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
    assign w_word      = {r_shift, in_data};
    assign w_len_n     = {r_len[15:8], in_data};
    assign w_last_word = (17'(r_word_idx) + 17'd1) == {1'b0, r_len};
    assign w_restart   = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
    always_comb begin
        w_next    = r_state;
        core_halt = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LEN_HI;
            S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if ({1'b0, w_len_n} > MAX_N) w_next = S_ERROR;
                    else if (w_len_n == 16'd0)   w_next = TAIL;
                    else                         w_next = S_DATA;
                end
            end
            S_DATA: if (w_word_done && w_last_word) w_next = TAIL;
`ifdef PROG_LOADER_CKSUM_EN
            S_CHECK: if (w_word_done) w_next = (w_word == r_xor) ? S_DONE : S_ERROR;
`endif
            S_DONE: begin
                core_halt = 1'b0;
                done      = 1'b1;
                if (start) w_next = S_LEN_HI;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) w_next = S_LEN_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: datapath state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_word_idx  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef PROG_LOADER_CKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (w_restart) begin
                r_byte_cnt <= '0;
                r_word_idx <= '0;
`ifdef PROG_LOADER_CKSUM_EN
                r_xor      <= '0;
`endif
            end
            if (w_accept) begin
                case (r_state)
                    S_LEN_HI: r_len[15:8] <= in_data;
                    S_LEN_LO: r_len[7:0]  <= in_data;
                    default: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_shift    <= {r_shift[15:0], in_data};
                        if (w_word_done && r_state == S_DATA) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_word_idx;
                            r_mem_wdata <= w_word;
`ifdef PROG_LOADER_CKSUM_EN
                            r_xor       <= r_xor ^ w_word;
`endif
                            // Holding on the last word keeps the index from wrapping at 2^ADDR_W.
                            if (!w_last_word) r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized loads against a byte-stream model.
module tb_prog_loader;
    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;
`ifdef PROG_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready, mem_we, core_halt, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_halt(core_halt), .done(done), .error(error)
    );

    always #5 clk1 = ~clk1;

    typedef logic [ADDR_W+31:0] wr_t;
    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    bit         exp_done, exp_err;
    int         total = 0, bad = 0;
    int         long_pulse = 0, halt_bad = 0, timeouts = 0;
    bit         prev_we = 1'b0;

    always @(negedge clk1) begin
        if (rst_n) begin
            if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
            if (mem_we && prev_we) long_pulse++;
            if (core_halt !== ~done) halt_bad++;
        end
        prev_we = mem_we;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic wr_t get_obs(input int i);
        return (i < obs_q.size()) ? obs_q[i] : '1;
    endfunction

    // Reference: interpret the byte stream directly as header, words and optional checksum.
    task automatic model();
        int          n;
        logic [31:0] x, w;
        exp_q.delete();
        x = 32'd0;
        n = int'({stim_q[0], stim_q[1]});
        if (n > MAX_WORDS) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = {stim_q[2+4*i], stim_q[3+4*i], stim_q[4+4*i], stim_q[5+4*i]};
            exp_q.push_back({ADDR_W'(i), w});
            x ^= w;
        end
        if (CK) begin
            w = {stim_q[2+4*n], stim_q[3+4*n], stim_q[4+4*n], stim_q[5+4*n]};
            exp_done = (w == x);
            exp_err  = (w != x);
        end else begin
            exp_done = 1'b1;
            exp_err  = 1'b0;
        end
    endtask

    task automatic add_cksum();
        int          n;
        logic [31:0] x;
        x = 32'd0;
        n = int'({stim_q[0], stim_q[1]});
        for (int i = 0; i < n; i++)
            x ^= {stim_q[2+4*i], stim_q[3+4*i], stim_q[4+4*i], stim_q[5+4*i]};
        for (int k = 3; k >= 0; k--) stim_q.push_back(8'(x >> (8*k)));
    endtask

    task automatic make_prog(input int n, input bit force_last);
        logic [31:0] w;
        stim_q.delete();
        stim_q.push_back(8'(n >> 8));
        stim_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (force_last && i == n - 1) w = 32'hfe000000;
            for (int k = 3; k >= 0; k--) stim_q.push_back(8'(w >> (8*k)));
        end
        if (CK) add_cksum();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sent = 1'b0;
        int tries = 0;
        while (!sent && tries < 50) begin
            @(negedge clk1);
            tries++;
            if ((gaps && $urandom_range(0, 2) == 0) || !in_ready) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                sent     = 1'b1;
            end
        end
        if (!sent) timeouts++;
    endtask

    task automatic start_load();
        model();
        long_pulse = 0;
        halt_bad   = 0;
        timeouts   = 0;
        @(negedge clk1);
        obs_q.delete();
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) send_byte(stim_q[i], gaps);
    endtask

    task automatic finish_load(input string tag);
        int c = 0;
        @(negedge clk1);
        in_valid = 1'b0;
        while (!(done || error) && c < 20) begin
            @(negedge clk1);
            c++;
        end
        repeat (3) @(negedge clk1);
        check({tag, ".nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) check($sformatf("%s.wr%0d", tag, i), 64'(get_obs(i)), 64'(exp_q[i]));
        check({tag, ".done"}, 64'(done), 64'(exp_done));
        check({tag, ".error"}, 64'(error), 64'(exp_err));
        check({tag, ".halt"}, 64'(core_halt), 64'(!exp_done));
        check({tag, ".ready"}, 64'(in_ready), 64'd0);
        check({tag, ".we_len"}, 64'(long_pulse), 64'd0);
        check({tag, ".halt_done"}, 64'(halt_bad), 64'd0);
        check({tag, ".stall"}, 64'(timeouts), 64'd0);
    endtask

    task automatic run_load(input string tag, input bit gaps);
        start_load();
        send_range(0, stim_q.size(), gaps);
        finish_load(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 64'(in_ready), 64'd0);
        check({tag, ".we"}, 64'(mem_we), 64'd0);
        check({tag, ".addr"}, 64'(mem_addr), 64'd0);
        check({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, ".halt"}, 64'(core_halt), 64'd1);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".error"}, 64'(error), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;

        // Two-word reference program from the datasheet example.
        stim_q = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0a, 8'h28, 8'h02, 8'h00, 8'h14};
        if (CK) add_cksum();
        run_load("basic", 1'b0);
        check("basic.w0", 64'(get_obs(0)), 64'({10'd0, 32'h2801000a}));
        check("basic.w1", 64'(get_obs(1)), 64'({10'd1, 32'h28020014}));

`ifdef PROG_LOADER_CKSUM_EN
        stim_q = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0a, 8'h28, 8'h02, 8'h00, 8'h14,
                   8'h00, 8'h03, 8'h00, 8'h1e};
        run_load("ck_good", 1'b0);
        stim_q = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0a, 8'h28, 8'h02, 8'h00, 8'h14,
                   8'h00, 8'h00, 8'h00, 8'h00};
        run_load("ck_bad", 1'b1);
`endif

        // Oversized count must abort without touching memory; zero count ends immediately.
        stim_q = '{8'h04, 8'h01};
        run_load("too_long", 1'b0);
        stim_q = '{8'h00, 8'h00};
        if (CK) add_cksum();
        run_load("empty", 1'b0);

        stim_q = '{8'h04, 8'h00};
        for (int i = 0; i < 4 * MAX_WORDS; i++) stim_q.push_back(8'($urandom));
        if (CK) add_cksum();
        run_load("max_len", 1'b0);

        make_prog(9, 1'b1);
        run_load("gappy9", 1'b1);
        for (int k = 0; k < 3; k++) begin
            make_prog($urandom_range(1, 6), 1'b0);
            run_load($sformatf("rand%0d", k), 1'b1);
        end

        // A start pulse in the middle of a load is ignored.
        make_prog(1, 1'b0);
        start_load();
        send_range(0, 4, 1'b0);
        @(negedge clk1);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        send_range(4, stim_q.size(), 1'b0);
        finish_load("midstart");

        // Asynchronous reset in the middle of word 1, then a clean reload from address 0.
        make_prog(2, 1'b0);
        start_load();
        send_range(0, 8, 1'b0);
        @(negedge clk1);
        in_valid = 1'b0;
        check("prerst.wdata", 64'(mem_wdata), 64'({stim_q[2], stim_q[3], stim_q[4], stim_q[5]}));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk1);
        rst_n = 1'b1;
        make_prog(3, 1'b0);
        run_load("after_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, meaning largest accepted program length in words (at most 2^ADDR_W).
REQ-003 SHALL have port clk1  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port in_valid  in  1  byte-stream valid.
REQ-007 SHALL have port in_data  in  8  byte-stream data.
REQ-008 SHALL have port in_ready  out  1  byte-stream ready.
REQ-009 SHALL have port mem_we  out  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  out  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port mem_wdata  out  32  instruction word to write.
REQ-012 SHALL have port core_halt  out  1  holds the core halted, with PC and branch flag cleared, while high.
REQ-013 SHALL have port done  out  1  load completed successfully.
REQ-014 SHALL have port error  out  1  load aborted.

Function
REQ-015 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
REQ-016 A byte SHALL be accepted only on a cycle with in_valid and in_ready both high; in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA and CHECK and 0 in all other states.
REQ-017 IDLE -> LEN_HI on start; start SHALL be ignored in every other state except DONE and ERROR, where it SHALL clear done/error and go to LEN_HI.
REQ-018 LEN_HI/LEN_LO SHALL capture the 16-bit big-endian word count N.
REQ-019 After LEN_LO: if N > MAX_WORDS -> ERROR; if N = 0 -> CHECK (macro set) or DONE (macro clear); otherwise -> DATA.
REQ-020 DATA SHALL assemble 4 accepted bytes big-endian (first byte = bits 31:24) into one word.
REQ-021 mem_we SHALL pulse high for exactly one cycle, the cycle after the 4th byte is accepted, with mem_addr = word index (0 for first word) and mem_wdata = assembled word.
REQ-022 Byte acceptance SHALL continue without stall while a write is pending; throughput is one byte per cycle.
REQ-023 After word N-1 is accepted: -> CHECK (macro set) or DONE (macro clear).
REQ-024 The word index SHALL never wrap; an index reaching MAX_WORDS is unreachable because of REQ-019.
REQ-025 core_halt SHALL be 1 in every state except DONE, and SHALL fall on the same edge at which done rises.
REQ-026 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR; both hold until start or reset.
REQ-027 in_valid low mid-word SHALL pause assembly with partial bytes retained.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_halt=1, done=0, error=0, and clear the byte and word counters, including mid-load.
REQ-029 Reset deassertion SHALL be sampled on clk1; the first legal start is the first edge with rst_n high.

Configuration
REQ-030 With PROG_LOADER_CKSUM_EN defined, CHECK SHALL accept 4 bytes forming a big-endian 32-bit word and compare it with the running XOR of all written words (0 for N=0): equal -> DONE, otherwise -> ERROR.
REQ-031 Without PROG_LOADER_CKSUM_EN, CHECK and the XOR accumulator SHALL not exist, and loads end at DONE per REQ-019/REQ-023.

Verification
REQ-032 Reset, start, stream 00 02 28 01 00 0a 28 02 00 14 -> writes (0, 32'h2801000a), (1, 32'h28020014); done=1; core_halt falls (macro clear).
REQ-033 Macro set: same stream plus checksum bytes 00 03 00 1e -> DONE; stream plus checksum 00 00 00 00 -> ERROR with error=1 and core_halt=1.
REQ-034 Count bytes 04 01 (N=1025, MAX_WORDS=1024) -> ERROR with no mem_we pulse; count 00 00 -> DONE (macro clear) with no writes.
REQ-035 in_valid toggled randomly across a 9-word program ending with word fe000000 -> identical writes and addresses, each mem_we exactly one cycle long.
REQ-036 rst_n low after 2 bytes of word 1 -> all outputs at reset values asynchronously; a new start then reloads from address 0.
